// File: rtl/maxf_pkg.sv
// Shared definitions for binary32 maximumf units: constants, helpers, FSM states.
package maxf_pkg;

  localparam logic [31:0] FP32_NEG_INF = 32'hFF800000;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EMIT
  } state_t;

  // A NaN has an all-ones exponent and a nonzero mantissa (quiet or signalling).
  function automatic logic fp32_is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Maps binary32 onto an unsigned key whose integer order matches numeric
  // order for non-NaN values, including -0 < +0 and exact subnormal ordering.
  function automatic logic [31:0] fp32_order_key(input logic [31:0] x);
    return x[31] ? ~x : (x | 32'h80000000);
  endfunction

endpackage

// File: rtl/maxf_cmp.sv
// Purely combinational two-operand binary32 maximumf, NaN-propagating.
module maxf_cmp
  import maxf_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic w_anyNan;
  logic w_aWins;

  assign w_anyNan = fp32_is_nan(a) || fp32_is_nan(b);
  assign w_aWins  = fp32_order_key(a) >= fp32_order_key(b);

  // Any NaN operand collapses to the canonical quiet NaN; otherwise larger key wins.
  always_comb begin
    y = b;
    if (w_anyNan) begin
      y = FP32_QNAN;
    end else if (w_aWins) begin
      y = a;
    end
  end

endmodule

// File: rtl/maxf_reduce.sv
// Counted-stream maximumf reduction: takes a count token, folds that many
// binary32 elements into an accumulator, then emits the single result token.
module maxf_reduce
  import maxf_pkg::*;
#(
  parameter int DATA_TYPE   = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   count_valid,
  output logic                   count_ready,
  input  logic [DATA_TYPE-1:0]   ins,
  input  logic                   ins_valid,
  output logic                   ins_ready,
  output logic [DATA_TYPE-1:0]   outs,
  output logic                   outs_valid,
  input  logic                   outs_ready
);

  // The comparator and constants are binary32-only, so refuse other widths.
  generate
    if (DATA_TYPE != 32) begin : g_badWidth
      $error("maxf_reduce supports only DATA_TYPE = 32");
    end
  endgenerate

  state_t                 r_state;
  state_t                 w_nextState;
  logic [31:0]            r_acc;
  logic [COUNT_WIDTH-1:0] r_remaining;
  logic [31:0]            w_max;
  logic                   w_countFire;
  logic                   w_insFire;
  logic                   w_lastElem;

  maxf_cmp u_cmp (
    .a (r_acc),
    .b (ins),
    .y (w_max)
  );

  assign w_countFire = count_valid && count_ready;
  assign w_insFire   = ins_valid && ins_ready;
  assign w_lastElem  = (r_remaining == COUNT_WIDTH'(1));
  assign outs        = r_acc;

  // State register; reset abandons any partial reduction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state plus handshake outputs, decoded from the current state only.
  always_comb begin
    w_nextState = r_state;
    count_ready = 1'b0;
    ins_ready   = 1'b0;
    outs_valid  = 1'b0;
    case (r_state)
      IDLE: begin
        count_ready = 1'b1;
        if (count_valid) begin
          w_nextState = (count == '0) ? EMIT : ACCUM;
        end
      end
      ACCUM: begin
        ins_ready = 1'b1;
        if (ins_valid && w_lastElem) begin
          w_nextState = EMIT;
        end
      end
      EMIT: begin
        outs_valid = 1'b1;
        if (outs_ready) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Accumulator and element counter; -inf seeds each reduction as the identity.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= FP32_NEG_INF;
      r_remaining <= '0;
    end else if (w_countFire) begin
      r_acc       <= FP32_NEG_INF;
      r_remaining <= count;
    end else if (w_insFire) begin
      r_acc       <= w_max;
      r_remaining <= r_remaining - COUNT_WIDTH'(1);
    end
  end

endmodule
